alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised, width-generic successor to the datapath's single-cycle ALU. Single-cycle ops (add/sub/compare/logic) are kept. It adds multi-bit iterative shifts and a shift-add multiply, run behind a start/busy/done handshake. The controller FSM issues an op, then stalls until done before writing d and the status flags into the register file and status register.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4).
AMT_W, $clog2(WIDTH), width of the shift-amount field taken from a.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  request; accepted only when busy=0.
f  input  4  operation code, sampled with start.
a  input  WIDTH  operand A, sampled with start.
b  input  WIDTH  operand B, sampled with start.
busy  output  1  high while iterating; start ignored.
done  output  1  one-cycle pulse; d and flags valid from this cycle.
d  output  WIDTH  result; held until next done.
carry, low, flag, zero, negative  output  1 each  status flags; held with d.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Ports are named clock and reset.
- Reset: state=IDLE; d=0; all flags 0; done=0; busy=0. Reset mid-operation aborts the op with no done pulse.
- States:
  - IDLE: if start, latch f/a/b. Go to EXEC if the op iterates with count>0, else to DONE.
  - EXEC: one step per edge; the counter decrements. After the last step, go to DONE.
  - DONE: done=1 for exactly this cycle. Next state is IDLE, or accept a new start (back-to-back allowed).
- busy=1 only in EXEC. A start during EXEC is ignored and must not corrupt the operation.
- Latency from start cycle to done cycle:
  - single-cycle ops: 1.
  - shifts: 1+n, where n=a[AMT_W-1:0]; n=0 gives 1.
  - MUL: WIDTH+1.
- Opcodes and flags (flags not listed are 0):
  - 0000 ADD: d=a+b mod 2^WIDTH. carry=carry-out; flag=signed overflow; zero=(d==0).
  - 0001 SUB: d=a-b. carry=borrow; flag=NOT signed overflow (legacy polarity); zero=(d==0).
  - 0010 CMP: d=a-b. zero=(a==b); low=(a<b) unsigned; negative=(a<b) signed.
  - 0011 AND, 0100 OR, 0101 XOR: d=bitwise result; zero=(d==0).
  - 0110 SHL: d=b<<n, zero fill. carry=last bit shifted out (0 if n=0); zero=(d==0).
  - 0111 SHR: d=b>>n, logical. carry=last bit shifted out (0 if n=0); zero=(d==0).
  - 1000 MUL: unsigned shift-add, one multiplier bit per cycle over an internal 2*WIDTH accumulator. d=low WIDTH bits; carry=OR of high WIDTH bits (overflow); zero=(d==0); negative=d[WIDTH-1].
  - Other codes: d=0, all flags 0, latency 1.
- d and flags update only on entry to DONE. They stay stable in IDLE and EXEC until the next done.

Optional Feature:
ALU_ROTATE_EN:
- Defined: adds 1001 ROL and 1010 ROR. d is b rotated by n, iterative, latency 1+n. carry=last bit rotated across (0 if n=0); zero=(d==0).
- Undefined: 1001 and 1010 decode as undefined ops (d=0, flags 0, latency 1).

Test Plan:
1. ADD a=0xFFFF, b=0x0001 -> done exactly 1 cycle after start; d=0x0000, carry=1, zero=1, busy never high.
2. CMP a=0x0001, b=0xFFFF -> d=0x0002, low=1, negative=0, zero=0; then CMP a=0x8000, b=0x0001 -> negative=1, low=0.
3. SHL a=4, b=0x0001 -> busy high 4 cycles; done 5 cycles after start; d=0x0010, carry=0. SHR a=1, b=0x0003 -> d=0x0001, carry=1, done at +2.
4. MUL a=3, b=5 -> done at +17 (WIDTH=16); d=0x000F, carry=0. MUL a=0x0100, b=0x0100 -> d=0x0000, carry=1, zero=1.
5. Start MUL 3*5, pulse start with ADD at cycle +5 -> ignored, result still 0x000F at +17. Assert reset at +8 -> busy=0, done=0, d=0 immediately; no done pulse follows.
6. Back-to-back: new ADD start issued in the DONE cycle of a SHL -> accepted; ADD done one cycle later. Repeat with WIDTH=32: MUL 0x00010000*0x00010000 -> d=0, carry=1, done at +33.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// ALU request/response bundle: start/f/a/b in, busy/done/d/flags out.
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       f;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             carry;
  logic             low;
  logic             flag;
  logic             zero;
  logic             negative;

  modport master (
    output start, f, a, b,
    input  busy, done, d, carry, low, flag, zero, negative
  );

  modport slave (
    input  start, f, a, b,
    output busy, done, d, carry, low, flag, zero, negative
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arith/logic, iterative shifts and shift-add MUL.
// Define ALU_ROTATE_EN to add ROL (1001) / ROR (1010).
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input logic            clock,
  input logic            reset,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;

`ifdef ALU_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [4:0]         fl_q, fl_d;

  logic [AMT_W-1:0]   n;
  logic [WIDTH:0]     addx, subx;
  logic [WIDTH-1:0]   res1;
  logic [4:0]         fl1;
  logic               iter1;

  assign n    = bus.a[AMT_W-1:0];
  assign addx = {1'b0, bus.a} + {1'b0, bus.b};
  assign subx = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    res1  = '0;
    fl1   = '0;
    iter1 = 1'b0;
    case (bus.f)
      OP_ADD: begin
        res1    = addx[WIDTH-1:0];
        fl1[FC] = addx[WIDTH];
        fl1[FF] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (addx[WIDTH-1] != bus.a[WIDTH-1]);
        fl1[FZ] = (res1 == '0);
      end
      OP_SUB: begin
        res1    = subx[WIDTH-1:0];
        fl1[FC] = subx[WIDTH];
        fl1[FF] = !((bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (subx[WIDTH-1] != bus.a[WIDTH-1]));
        fl1[FZ] = (res1 == '0);
      end
      OP_CMP: begin
        res1    = subx[WIDTH-1:0];
        fl1[FZ] = (bus.a == bus.b);
        fl1[FL] = subx[WIDTH];
        fl1[FN] = ($signed(bus.a) < $signed(bus.b));
      end
      OP_AND, OP_OR, OP_XOR: begin
        res1    = (bus.f == OP_AND) ? (bus.a & bus.b) :
                  (bus.f == OP_OR)  ? (bus.a | bus.b) :
                                      (bus.a ^ bus.b);
        fl1[FZ] = (res1 == '0);
      end
      OP_SHL, OP_SHR: begin
        res1    = bus.b;
        fl1[FZ] = (bus.b == '0);
        iter1   = (n != '0);
      end
      OP_ROL, OP_ROR: begin
        if (ROT_EN) begin
          res1    = bus.b;
          fl1[FZ] = (bus.b == '0);
          iter1   = (n != '0);
        end
      end
      OP_MUL: iter1 = 1'b1;
      default: ;
    endcase
  end

  logic [WIDTH-1:0]   v;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_c;
  logic [WIDTH-1:0]   fin_d;
  logic [4:0]         fin_fl;

  assign v    = acc_q[WIDTH-1:0];
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, mc_q} : '0);

  // Shifts work in the low half; MUL adds into the high half and shifts right.
  always_comb begin
    step_acc = acc_q;
    step_c   = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_acc[WIDTH-1:0] = {v[WIDTH-2:0], 1'b0};
        step_c              = v[WIDTH-1];
      end
      OP_SHR: begin
        step_acc[WIDTH-1:0] = {1'b0, v[WIDTH-1:1]};
        step_c              = v[0];
      end
      OP_ROL: begin
        step_acc[WIDTH-1:0] = {v[WIDTH-2:0], v[WIDTH-1]};
        step_c              = v[WIDTH-1];
      end
      OP_ROR: begin
        step_acc[WIDTH-1:0] = {v[0], v[WIDTH-1:1]};
        step_c              = v[0];
      end
      OP_MUL: step_acc = {msum, acc_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_comb begin
    fin_d      = step_acc[WIDTH-1:0];
    fin_fl     = '0;
    fin_fl[FZ] = (fin_d == '0);
    if (op_q == OP_MUL) begin
      fin_fl[FC] = |step_acc[2*WIDTH-1:WIDTH];
      fin_fl[FN] = fin_d[WIDTH-1];
    end else begin
      fin_fl[FC] = step_c;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    d_d     = d_q;
    fl_d    = fl_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          op_d  = bus.f;
          mc_d  = bus.a;
          acc_d = {{WIDTH{1'b0}}, bus.b};
          cnt_d = (bus.f == OP_MUL) ? CW'(WIDTH) : CW'(n);
          if (iter1) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_DONE;
            d_d     = res1;
            fl_d    = fl1;
          end
        end
      end
      S_EXEC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          d_d     = fin_d;
          fl_d    = fin_fl;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      d_q     <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      d_q     <= d_d;
      fl_q    <= fl_d;
    end
  end

  assign bus.busy     = (state_q == S_EXEC);
  assign bus.done     = (state_q == S_DONE);
  assign bus.d        = d_q;
  assign bus.carry    = fl_q[FC];
  assign bus.low      = fl_q[FL];
  assign bus.flag     = fl_q[FF];
  assign bus.zero     = fl_q[FZ];
  assign bus.negative = fl_q[FN];
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases, abort/back-to-back, random vs model.
module tb_alu_multicycle;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  alu_multicycle_if #(.WIDTH(16)) bus ();
  alu_multicycle_if #(.WIDTH(32)) bus32 ();

  alu_multicycle #(.WIDTH(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clock(clock),
    .reset(reset),
    .bus  (bus32.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags16();
    return {bus.carry, bus.low, bus.flag, bus.zero, bus.negative};
  endfunction

  // Reference: plain integer arithmetic on the opcode table.
  function automatic void model(input logic [3:0] f, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] d,
                                output logic [4:0] fl, output int lat);
    int n;
    longint ua, ub, sa, sb, r;
    logic c, lo, fg, z, ng;
    n  = int'(a[3:0]);
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0; lo = 0; fg = 0; z = 0; ng = 0;
    d = '0;
    lat = 1;
    case (f)
      4'd0: begin
        r = ua + ub; d = r[15:0]; c = (r >= 65536);
        fg = (sa + sb > 32767) || (sa + sb < -32768); z = (d == 0);
      end
      4'd1: begin
        r = ua - ub; d = r[15:0]; c = (ua < ub);
        fg = !((sa - sb > 32767) || (sa - sb < -32768)); z = (d == 0);
      end
      4'd2: begin
        r = ua - ub; d = r[15:0];
        z = (ua == ub); lo = (ua < ub); ng = (sa < sb);
      end
      4'd3: begin d = a & b; z = (d == 0); end
      4'd4: begin d = a | b; z = (d == 0); end
      4'd5: begin d = a ^ b; z = (d == 0); end
      4'd6: begin
        lat = 1 + n; d = 16'(b << n); z = (d == 0);
        c = (n > 0) ? b[16-n] : 1'b0;
      end
      4'd7: begin
        lat = 1 + n; d = b >> n; z = (d == 0);
        c = (n > 0) ? b[n-1] : 1'b0;
      end
      4'd8: begin
        lat = 17; r = ua * ub; d = r[15:0];
        c = ((r >> 16) != 0); z = (d == 0); ng = d[15];
      end
`ifdef ALU_ROTATE_EN
      4'd9: begin
        lat = 1 + n;
        d = (n > 0) ? 16'((b << n) | (b >> (16 - n))) : b;
        z = (d == 0); c = (n > 0) ? d[0] : 1'b0;
      end
      4'd10: begin
        lat = 1 + n;
        d = (n > 0) ? 16'((b >> n) | (b << (16 - n))) : b;
        z = (d == 0); c = (n > 0) ? d[15] : 1'b0;
      end
`endif
      default: ;
    endcase
    fl = {c, lo, fg, z, ng};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] f,
                        input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] od, output logic [4:0] ofl,
                        output int olat);
    logic [15:0] ed;
    logic [4:0]  efl;
    int elat, bcnt;
    model(f, a, b, ed, efl, elat);
    @(negedge clock);
    bus.start = 1'b1; bus.f = f; bus.a = a; bus.b = b;
    @(negedge clock);
    bus.start = 1'b0;
    olat = 0;
    bcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin
        olat = k;
        break;
      end
      if (bus.busy) bcnt++;
      @(negedge clock);
    end
    od  = bus.d;
    ofl = flags16();
    chk({tag, " lat"}, 64'(olat), 64'(elat));
    chk({tag, " busy"}, 64'(bcnt), 64'(elat - 1));
    chk({tag, " d"}, 64'(od), 64'(ed));
    chk({tag, " flags"}, 64'(ofl), 64'(efl));
    @(negedge clock);
    chk({tag, " pulse"}, 64'(bus.done), 64'(0));
    chk({tag, " hold"}, 64'(bus.d), 64'(ed));
  endtask

  initial begin
    logic [15:0] d;
    logic [4:0]  fl;
    int lat, cnt;
    logic [15:0] pick [5];

    bus.start = 0; bus.f = 0; bus.a = 0; bus.b = 0;
    bus32.start = 0; bus32.f = 0; bus32.a = 0; bus32.b = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst d", 64'(bus.d), 64'(0));
    chk("rst flags", 64'(flags16()), 64'(0));
    chk("rst busy", 64'(bus.busy), 64'(0));
    chk("rst done", 64'(bus.done), 64'(0));
    reset = 1'b0;

    run_op("add", 4'd0, 16'hFFFF, 16'h0001, d, fl, lat);
    chk("add d0", 64'(d), 64'h0);
    chk("add fl0", 64'(fl), 64'(5'b10010));
    run_op("cmp1", 4'd2, 16'h0001, 16'hFFFF, d, fl, lat);
    chk("cmp1 d0", 64'(d), 64'h2);
    chk("cmp1 fl0", 64'(fl), 64'(5'b01000));
    run_op("cmp2", 4'd2, 16'h8000, 16'h0001, d, fl, lat);
    chk("cmp2 fl0", 64'(fl), 64'(5'b00001));
    run_op("shl", 4'd6, 16'd4, 16'h0001, d, fl, lat);
    chk("shl d0", 64'(d), 64'h10);
    chk("shl lat0", 64'(lat), 64'(5));
    run_op("shr", 4'd7, 16'd1, 16'h0003, d, fl, lat);
    chk("shr fl0", 64'(fl), 64'(5'b10000));
    run_op("mul1", 4'd8, 16'd3, 16'd5, d, fl, lat);
    chk("mul1 d0", 64'(d), 64'hF);
    chk("mul1 lat0", 64'(lat), 64'(17));
    run_op("mul2", 4'd8, 16'h0100, 16'h0100, d, fl, lat);
    chk("mul2 fl0", 64'(fl), 64'(5'b10010));
    run_op("undef", 4'd15, 16'h1234, 16'h00FF, d, fl, lat);
    run_op("shl0", 4'd6, 16'h0010, 16'h8001, d, fl, lat);
    run_op("shlout", 4'd6, 16'h000F, 16'h0001, d, fl, lat);

    // A start during EXEC must be ignored.
    @(negedge clock);
    bus.start = 1; bus.f = 4'd8; bus.a = 16'd3; bus.b = 16'd5;
    @(negedge clock);
    bus.start = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus.start = 1; bus.f = 4'd0; bus.a = 16'd1; bus.b = 16'd1;
      end else begin
        bus.start = 0;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    bus.start = 0;
    chk("ign lat", 64'(lat), 64'(17));
    chk("ign d", 64'(bus.d), 64'hF);

    // Reset mid-MUL aborts with no done pulse.
    @(negedge clock);
    bus.start = 1; bus.f = 4'd8; bus.a = 16'd7; bus.b = 16'd9;
    @(negedge clock);
    bus.start = 0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort busy", 64'(bus.busy), 64'(0));
    chk("abort done", 64'(bus.done), 64'(0));
    chk("abort d", 64'(bus.d), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) cnt++;
      @(negedge clock);
    end
    chk("abort nodone", 64'(cnt), 64'(0));

    // Back-to-back: ADD issued in the DONE cycle of a SHL.
    @(negedge clock);
    bus.start = 1; bus.f = 4'd6; bus.a = 16'd2; bus.b = 16'h0001;
    @(negedge clock);
    bus.start = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    chk("b2b shl lat", 64'(lat), 64'(3));
    chk("b2b shl d", 64'(bus.d), 64'h4);
    bus.start = 1; bus.f = 4'd0; bus.a = 16'd5; bus.b = 16'd6;
    @(negedge clock);
    bus.start = 0;
    chk("b2b add done", 64'(bus.done), 64'(1));
    chk("b2b add d", 64'(bus.d), 64'hB);

    // 32-bit instance: overflowing MUL.
    @(negedge clock);
    bus32.start = 1; bus32.f = 4'd8;
    bus32.a = 32'h0001_0000; bus32.b = 32'h0001_0000;
    @(negedge clock);
    bus32.start = 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus32.done) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    chk("w32 lat", 64'(lat), 64'(33));
    chk("w32 d", 64'(bus32.d), 64'(0));
    chk("w32 carry", 64'(bus32.carry), 64'(1));
    chk("w32 zero", 64'(bus32.zero), 64'(1));

    pick[0] = 16'h0000; pick[1] = 16'hFFFF;
    pick[2] = 16'h8000; pick[3] = 16'h7FFF; pick[4] = 16'h0001;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  rf;
      logic [15:0] ra, rb;
      rf = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)]
                                       : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)]
                                       : 16'($urandom);
      run_op($sformatf("rnd%0d", i), rf, ra, rb, d, fl, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
